// File: rtl/voltmeter_pkg.sv
// Shared encodings for the dual-slope conversion sequencer and its analog control bus.
package voltmeter_pkg;

  localparam logic [1:0] AFE_AZ    = 2'b00;
  localparam logic [1:0] AFE_VIN   = 2'b01;
  localparam logic [1:0] AFE_VREFP = 2'b10;
  localparam logic [1:0] AFE_VREFN = 2'b11;

  localparam int RANGE_W   = 3;
  localparam int RANGE_MAX = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_REFW  = 3'd2,
    S_AZ    = 3'd3,
    S_INT   = 3'd4,
    S_DEINT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs from the analog side.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/dual_slope_seq.sv
// Dual-slope conversion sequencer: reset, ref wait, auto-zero, integrate, timed
// deintegrate, with autoranging and overrange/ref-timeout reporting.
module dual_slope_seq
  import voltmeter_pkg::*;
#(
  parameter int T_RST       = 4,
  parameter int T_AZ        = 256,
  parameter int T_INT       = 1000,
  parameter int CNT_W       = 16,
  parameter int N_DEINT_MAX = 2000,
  parameter int REF_TMO     = 4096,
  parameter int LO_THR      = 180
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             abort_i,
  input  logic [1:0]       mode_sel_i,
  input  logic             range_auto_i,
  input  logic [2:0]       range_man_i,
  input  logic             comp_i,
  input  logic             sat_hi_i,
  input  logic             sat_lo_i,
  input  logic             ref_ok_i,
  output logic [1:0]       afe_sel_o,
  output logic [2:0]       range_sel_o,
  output logic             afe_reset_o,
  output logic             ref_sign_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] result_o,
  output logic             result_sign_o,
  output logic             result_valid_o,
  output logic             overrange_o,
  output logic             ref_err_o
);

  localparam int TMR_MAX1 = (REF_TMO > N_DEINT_MAX) ? REF_TMO : N_DEINT_MAX;
  localparam int TMR_MAX2 = (T_INT > T_AZ) ? T_INT : T_AZ;
  localparam int TMR_MAX  = (TMR_MAX1 > TMR_MAX2) ? TMR_MAX1 : TMR_MAX2;
  localparam int TW       = $clog2(TMR_MAX + 1);

  logic [3:0] w_sync;
  logic       w_comp_s, w_sat_hi_s, w_sat_lo_s, w_ref_ok_s;

  sync_2ff #(.W(4)) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   ({comp_i, sat_hi_i, sat_lo_i, ref_ok_i}),
    .q_o   (w_sync)
  );
  assign {w_comp_s, w_sat_hi_s, w_sat_lo_s, w_ref_ok_s} = w_sync;

  state_t             r_state, w_nxt;
  logic [TW-1:0]      r_tmr;
  logic [1:0]         r_mode;
  logic               r_pol;
  logic [RANGE_W-1:0] r_range;
  logic [CNT_W-1:0]   r_result;
  logic               r_sign, r_ovr, r_err;

  logic w_sat, w_abort, w_tmr_clr, w_ld, w_ld_ovr, w_latch;
  logic w_set_err, w_clr_err, w_pol_ld, w_autorng;

  assign w_sat   = w_sat_hi_s | w_sat_lo_s;
  assign w_abort = abort_i | (mode_sel_i != r_mode);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_tmr_clr   = 1'b0;
    w_ld        = 1'b0;
    w_ld_ovr    = 1'b0;
    w_latch     = 1'b0;
    w_set_err   = 1'b0;
    w_clr_err   = 1'b0;
    w_pol_ld    = 1'b0;
    w_autorng   = 1'b0;
    afe_sel_o   = AFE_AZ;
    afe_reset_o = 1'b0;
    ref_sign_o  = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy_o      = 1'b0;
        afe_reset_o = 1'b1;
        w_tmr_clr   = 1'b1;
        if (start_i && !abort_i) begin
          w_nxt     = S_RST;
          w_latch   = 1'b1;
          w_clr_err = 1'b1;
        end
      end
      S_RST: begin
        afe_reset_o = 1'b1;
        if (r_tmr == TW'(T_RST - 1)) begin
          w_nxt     = S_REFW;
          w_tmr_clr = 1'b1;
        end
      end
      S_REFW: begin
        if (w_ref_ok_s) begin
          w_nxt     = S_AZ;
          w_tmr_clr = 1'b1;
        end else if (r_tmr == TW'(REF_TMO - 1)) begin
          w_nxt     = S_IDLE;
          w_set_err = 1'b1;
          w_tmr_clr = 1'b1;
        end
      end
      S_AZ: begin
        if (r_tmr == TW'(T_AZ - 1)) begin
          w_nxt     = S_INT;
          w_tmr_clr = 1'b1;
        end
      end
      S_INT: begin
        afe_sel_o = AFE_VIN;
        if (w_sat) begin
          w_nxt    = S_DONE;
          w_ld_ovr = 1'b1;
        end else if (r_tmr == TW'(T_INT - 1)) begin
          w_nxt     = S_DEINT;
          w_pol_ld  = 1'b1;
          w_tmr_clr = 1'b1;
        end
      end
      S_DEINT: begin
        afe_sel_o  = r_pol ? AFE_VREFN : AFE_VREFP;
        ref_sign_o = r_pol;
        // comp_s lags the integrator by two cycles; that lag is part of the count
        if (w_sat) begin
          w_nxt    = S_DONE;
          w_ld_ovr = 1'b1;
        end else if (w_comp_s != r_pol) begin
          w_nxt = S_DONE;
          w_ld  = 1'b1;
        end else if (r_tmr == TW'(N_DEINT_MAX - 1)) begin
          w_nxt    = S_DONE;
          w_ld_ovr = 1'b1;
        end
      end
      S_DONE: begin
        afe_reset_o = 1'b1;
        w_autorng   = 1'b1;
        w_tmr_clr   = 1'b1;
        if (cont_i) begin
          w_nxt   = S_RST;
          w_latch = 1'b1;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      default: begin
        w_nxt     = S_IDLE;
        w_tmr_clr = 1'b1;
      end
    endcase
    if (w_abort && r_state != S_IDLE) begin
      w_nxt     = S_IDLE;
      w_tmr_clr = 1'b1;
      w_ld      = 1'b0;
      w_ld_ovr  = 1'b0;
      w_latch   = 1'b0;
      w_set_err = 1'b0;
      w_pol_ld  = 1'b0;
      w_autorng = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmr    <= '0;
      r_mode   <= '0;
      r_pol    <= 1'b0;
      r_range  <= RANGE_W'(RANGE_MAX);
      r_result <= '0;
      r_sign   <= 1'b0;
      r_ovr    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_tmr <= w_tmr_clr ? '0 : r_tmr + 1'b1;
      if (w_latch) begin
        r_mode <= mode_sel_i;
        if (!range_auto_i) r_range <= range_man_i;
      end
      if (w_pol_ld) r_pol <= w_comp_s;
      if (w_ld) begin
        r_result <= CNT_W'(r_tmr);
        r_ovr    <= 1'b0;
        r_sign   <= ~r_pol;
      end else if (w_ld_ovr) begin
        r_result <= '1;
        r_ovr    <= 1'b1;
        r_sign   <= ~r_pol;
      end
      if (w_autorng && range_auto_i) begin
        if (r_ovr && r_range < RANGE_W'(RANGE_MAX))
          r_range <= r_range + 1'b1;
        else if (!r_ovr && r_result < CNT_W'(LO_THR) && r_range != '0)
          r_range <= r_range - 1'b1;
      end
      if (w_set_err)      r_err <= 1'b1;
      else if (w_clr_err) r_err <= 1'b0;
    end
  end

  assign range_sel_o    = r_range;
  assign result_o       = r_result;
  assign result_sign_o  = r_sign;
  assign overrange_o    = r_ovr;
  assign ref_err_o      = r_err;
  assign result_valid_o = (r_state == S_DONE);

endmodule

// File: tb/tb_dual_slope_seq.sv
// Directed-vector bench for dual_slope_seq with shortened timing parameters.
module tb_dual_slope_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni, start_i, cont_i, abort_i, range_auto_i;
  logic [1:0]  mode_sel_i;
  logic [2:0]  range_man_i;
  logic        comp_i, sat_hi_i, sat_lo_i, ref_ok_i;
  logic [1:0]  afe_sel_o;
  logic [2:0]  range_sel_o;
  logic        afe_reset_o, ref_sign_o, busy_o;
  logic [15:0] result_o;
  logic        result_sign_o, result_valid_o, overrange_o, ref_err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  dual_slope_seq #(
    .T_RST(2), .T_AZ(4), .T_INT(16), .CNT_W(16),
    .N_DEINT_MAX(64), .REF_TMO(32), .LO_THR(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .cont_i(cont_i),
    .abort_i(abort_i), .mode_sel_i(mode_sel_i), .range_auto_i(range_auto_i),
    .range_man_i(range_man_i), .comp_i(comp_i), .sat_hi_i(sat_hi_i),
    .sat_lo_i(sat_lo_i), .ref_ok_i(ref_ok_i), .afe_sel_o(afe_sel_o),
    .range_sel_o(range_sel_o), .afe_reset_o(afe_reset_o), .ref_sign_o(ref_sign_o),
    .busy_o(busy_o), .result_o(result_o), .result_sign_o(result_sign_o),
    .result_valid_o(result_valid_o), .overrange_o(overrange_o), .ref_err_o(ref_err_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_sel(input logic [1:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (afe_sel_o === s) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // run n cycles, counting valid pulses and capturing the last result seen
  task automatic collect(input int n, output int nvalid, output logic [15:0] res,
                         output logic sgn, output logic ovr);
    nvalid = 0; res = 'x; sgn = 1'bx; ovr = 1'bx;
    for (int i = 0; i < n; i++) begin
      step();
      if (result_valid_o === 1'b1) begin
        nvalid++;
        res = result_o; sgn = result_sign_o; ovr = overrange_o;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 0; cont_i = 0; abort_i = 0; mode_sel_i = 0;
    range_auto_i = 0; range_man_i = 0; comp_i = 0; sat_hi_i = 0; sat_lo_i = 0; ref_ok_i = 0;
    step(); step();
    checks++; if (afe_sel_o !== 2'b00) begin failures++; $display("FAIL reset_afe_sel got=%b exp=00", afe_sel_o); end
    checks++; if (afe_reset_o !== 1'b1) begin failures++; $display("FAIL reset_afe_reset got=%b exp=1", afe_reset_o); end
    checks++; if (range_sel_o !== 3'd7) begin failures++; $display("FAIL reset_range got=%0d exp=7", range_sel_o); end
    checks++; if ({busy_o, result_valid_o, overrange_o, ref_err_o, ref_sign_o, result_sign_o} !== 6'b0)
      begin failures++; $display("FAIL reset_flags got=%b exp=000000",
        {busy_o, result_valid_o, overrange_o, ref_err_o, ref_sign_o, result_sign_o}); end
    checks++; if (result_o !== 16'h0) begin failures++; $display("FAIL reset_result got=%h exp=0000", result_o); end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_pos_input();
    bit ok; int nv; logic [15:0] res; logic sgn, ovr;
    ref_ok_i = 1; comp_i = 1; range_auto_i = 0; range_man_i = 3'd3;
    step(); step(); step();
    pulse_start();
    checks++; if (afe_sel_o !== 2'b00 || busy_o !== 1'b1) begin failures++;
      $display("FAIL pos_start_sel got=%b busy=%b exp=00 busy=1", afe_sel_o, busy_o); end
    wait_sel(2'b01, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pos_int_reached got=timeout exp=afe_sel 01"); end
    wait_sel(2'b11, 100, ok);
    checks++; if (!ok || ref_sign_o !== 1'b1) begin failures++;
      $display("FAIL pos_deint_sel ok=%0d ref_sign=%b exp=afe_sel 11 ref_sign 1", ok, ref_sign_o); end
    for (int i = 0; i < 10; i++) step();
    comp_i = 0;
    collect(20, nv, res, sgn, ovr);
    checks++; if (nv !== 1) begin failures++; $display("FAIL pos_valid_count got=%0d exp=1", nv); end
    checks++; if (res !== 16'd12 || sgn !== 1'b0 || ovr !== 1'b0) begin failures++;
      $display("FAIL pos_result got=%0d sign=%b ovr=%b exp=12 sign=0 ovr=0", res, sgn, ovr); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL pos_idle_after got busy=%b exp=0", busy_o); end
  endtask

  task automatic test_neg_input();
    bit ok; int nv; logic [15:0] res; logic sgn, ovr;
    comp_i = 0;
    step(); step(); step();
    pulse_start();
    wait_sel(2'b10, 300, ok);
    checks++; if (!ok || ref_sign_o !== 1'b0) begin failures++;
      $display("FAIL neg_deint_sel ok=%0d ref_sign=%b exp=afe_sel 10 ref_sign 0", ok, ref_sign_o); end
    for (int i = 0; i < 5; i++) step();
    comp_i = 1;
    collect(20, nv, res, sgn, ovr);
    checks++; if (nv !== 1 || res !== 16'd7 || sgn !== 1'b1) begin failures++;
      $display("FAIL neg_result valids=%0d got=%0d sign=%b exp=1 valid 7 sign=1", nv, res, sgn); end
  endtask

  task automatic test_autorange();
    bit ok; int n, nv; logic [15:0] res; logic sgn, ovr;
    range_auto_i = 1; comp_i = 1;
    step(); step(); step();
    pulse_start();
    wait_sel(2'b11, 300, ok);
    checks++; if (!ok || range_sel_o !== 3'd3) begin failures++;
      $display("FAIL ar_range_in_deint ok=%0d got=%0d exp=3", ok, range_sel_o); end
    n = 0;
    while (afe_sel_o === 2'b11 && n < 200) begin n++; step(); end
    checks++; if (n !== 64) begin failures++; $display("FAIL ar_deint_len got=%0d exp=64", n); end
    checks++; if (result_valid_o !== 1'b1 || overrange_o !== 1'b1 || result_o !== 16'hFFFF) begin
      failures++; $display("FAIL ar_overrange valid=%b ovr=%b res=%h exp=1 1 FFFF",
        result_valid_o, overrange_o, result_o); end
    step();
    checks++; if (range_sel_o !== 3'd4) begin failures++; $display("FAIL ar_range_up got=%0d exp=4", range_sel_o); end
    pulse_start();
    wait_sel(2'b11, 300, ok);
    for (int i = 0; i < 3; i++) step();
    comp_i = 0;
    collect(20, nv, res, sgn, ovr);
    checks++; if (nv !== 1 || res !== 16'd5 || ovr !== 1'b0) begin failures++;
      $display("FAIL ar_small_result valids=%0d got=%0d ovr=%b exp=1 5 0", nv, res, ovr); end
    checks++; if (range_sel_o !== 3'd3) begin failures++; $display("FAIL ar_range_down got=%0d exp=3", range_sel_o); end
  endtask

  task automatic test_sat();
    bit ok; int n;
    comp_i = 1; range_auto_i = 0; range_man_i = 3'd7;
    step(); step(); step();
    pulse_start();
    range_auto_i = 1;
    wait_sel(2'b01, 300, ok);
    for (int i = 0; i < 5; i++) step();
    sat_hi_i = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(); n++;
      if (result_valid_o === 1'b1) break;
    end
    checks++; if (result_valid_o !== 1'b1 || n > 3) begin failures++;
      $display("FAIL sat_done_latency got=%0d cycles valid=%b exp<=3 valid=1", n, result_valid_o); end
    checks++; if (overrange_o !== 1'b1 || result_o !== 16'hFFFF) begin failures++;
      $display("FAIL sat_overrange ovr=%b res=%h exp=1 FFFF", overrange_o, result_o); end
    step();
    checks++; if (range_sel_o !== 3'd7) begin failures++; $display("FAIL sat_range_hold got=%0d exp=7", range_sel_o); end
    sat_hi_i = 0;
    step(); step(); step();
  endtask

  task automatic test_ref_timeout();
    int n, nv;
    ref_ok_i = 0;
    step(); step(); step();
    pulse_start();
    n = 0; nv = 0;
    while (ref_err_o !== 1'b1 && n < 100) begin
      step(); n++;
      if (result_valid_o === 1'b1) nv++;
    end
    checks++; if (n !== 34) begin failures++; $display("FAIL ref_tmo_cycles got=%0d exp=34", n); end
    checks++; if (ref_err_o !== 1'b1 || busy_o !== 1'b0 || nv !== 0) begin failures++;
      $display("FAIL ref_tmo_state err=%b busy=%b valids=%0d exp=1 0 0", ref_err_o, busy_o, nv); end
    ref_ok_i = 1;
    pulse_start();
    checks++; if (ref_err_o !== 1'b0) begin failures++; $display("FAIL ref_err_clear got=%b exp=0", ref_err_o); end
    abort_i = 1; step(); abort_i = 0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ref_abort got busy=%b exp=0", busy_o); end
  endtask

  task automatic test_back_to_back();
    int nv; bit ok;
    range_auto_i = 0; range_man_i = 3'd2; sat_hi_i = 1; cont_i = 1;
    step(); step(); step();
    pulse_start();
    nv = 0;
    for (int i = 0; i < 200 && nv < 3; i++) begin
      step();
      if (result_valid_o === 1'b1) nv++;
    end
    checks++; if (nv !== 3 || busy_o !== 1'b1) begin failures++;
      $display("FAIL b2b_restarts valids=%0d busy=%b exp=3 1", nv, busy_o); end
    step();
    cont_i = 0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (result_valid_o === 1'b1) begin ok = 1'b1; break; end
    end
    step();
    checks++; if (!ok || busy_o !== 1'b0) begin failures++;
      $display("FAIL b2b_stop last_valid=%0d busy=%b exp=1 0", ok, busy_o); end
    sat_hi_i = 0;
    step(); step(); step();
  endtask

  task automatic test_abort();
    bit ok; int nv; logic [15:0] prev, res; logic sgn, ovr;
    comp_i = 1; cont_i = 1;
    step(); step(); step();
    prev = result_o;
    pulse_start();
    wait_sel(2'b11, 300, ok);
    for (int i = 0; i < 3; i++) step();
    abort_i = 1; step(); abort_i = 0;
    checks++; if (busy_o !== 1'b0 || afe_reset_o !== 1'b1 || afe_sel_o !== 2'b00) begin failures++;
      $display("FAIL abort_idle busy=%b afe_reset=%b sel=%b exp=0 1 00", busy_o, afe_reset_o, afe_sel_o); end
    collect(20, nv, res, sgn, ovr);
    checks++; if (nv !== 0 || busy_o !== 1'b0 || result_o !== prev) begin failures++;
      $display("FAIL abort_no_valid valids=%0d busy=%b res=%h exp=0 0 %h", nv, busy_o, result_o, prev); end
    pulse_start();
    step(); step();
    mode_sel_i = 2'd1; step(); mode_sel_i = 2'd0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mode_change_abort busy=%b exp=0", busy_o); end
    pulse_start();
    wait_sel(2'b01, 300, ok);
    step(); step(); step();
    rst_ni = 1'b0;
    #1;
    checks++; if (afe_sel_o !== 2'b00 || afe_reset_o !== 1'b1 || range_sel_o !== 3'd7 || busy_o !== 1'b0) begin
      failures++; $display("FAIL async_rst_ctrl sel=%b afe_reset=%b range=%0d busy=%b exp=00 1 7 0",
        afe_sel_o, afe_reset_o, range_sel_o, busy_o); end
    checks++; if (result_o !== 16'h0 || overrange_o !== 1'b0 || result_valid_o !== 1'b0 || ref_err_o !== 1'b0) begin
      failures++; $display("FAIL async_rst_result res=%h ovr=%b valid=%b err=%b exp=0000 0 0 0",
        result_o, overrange_o, result_valid_o, ref_err_o); end
    cont_i = 0;
    step();
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_pos_input();
    test_neg_input();
    test_autorange();
    test_sat();
    test_ref_timeout();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
